// File: rtl/fibo_checker_sync_rst_if.sv
// Sample stream into the Fibonacci checker and its status outputs.
interface fibo_checker_sync_rst_if #(
   parameter int unsigned WIDTH = 4
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             restart;
   logic             match;
   logic             mismatch;
   logic             err_sticky;
   logic [WIDTH-1:0] exp_next;
   logic [7:0]       term_count;
   logic             locked;

   // Producer of samples / consumer of checker status
   modport master (
      output in_valid, in_data, restart,
      input  match, mismatch, err_sticky, exp_next, term_count, locked
   );

   // Checker side
   modport slave (
      input  in_valid, in_data, restart,
      output match, mismatch, err_sticky, exp_next, term_count, locked
   );
endinterface

// File: rtl/fibo_checker_sync_rst.sv
// Checks an incoming stream against the Fibonacci recurrence (mod 2^WIDTH).
module fibo_checker_sync_rst #(
   parameter int unsigned WIDTH       = 4,
   parameter bit          STRICT_SEED = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   fibo_checker_sync_rst_if.slave bus
);
   localparam int unsigned      CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {SEED0, SEED1, TRACK, ERR} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] t0_q, t0_d;
   logic [WIDTH-1:0] t1_q, t1_d;
   logic [WIDTH-1:0] exp_next_q, exp_next_d;
   logic [WIDTH-1:0] sum_c;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match_q, match_d;
   logic             mismatch_q, mismatch_d;
   logic             err_q, err_d;
   logic             locked_q, locked_d;

   // Next Fibonacci term; carry out of the top bit is intentionally dropped
   assign sum_c = t0_q + t1_q;

   // Next-state, term history and pulse decode
   always_comb begin
      state_d    = state_q;
      t0_d       = t0_q;
      t1_d       = t1_q;
      cnt_d      = cnt_q;
      match_d    = 1'b0;
      mismatch_d = 1'b0;

      if (bus.restart) begin
         state_d = SEED0;
         t0_d    = '0;
         t1_d    = '0;
         cnt_d   = '0;
      end else if (bus.in_valid) begin
         case (state_q)
            SEED0: begin
               if (!STRICT_SEED || (bus.in_data == '0)) begin
                  t0_d    = bus.in_data;
                  match_d = 1'b1;
                  state_d = SEED1;
               end else begin
                  mismatch_d = 1'b1;
                  state_d    = ERR;
               end
            end
            SEED1: begin
               if (!STRICT_SEED || (bus.in_data == WIDTH'(1))) begin
                  t1_d    = bus.in_data;
                  match_d = 1'b1;
                  state_d = TRACK;
               end else begin
                  mismatch_d = 1'b1;
                  state_d    = ERR;
               end
            end
            TRACK: begin
               if (bus.in_data == sum_c) begin
                  t0_d    = t1_q;
                  t1_d    = bus.in_data;
                  match_d = 1'b1;
               end else begin
                  mismatch_d = 1'b1;
                  state_d    = ERR;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      // Count every matched term, seeds included, holding at the ceiling
      if (match_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      err_d      = (state_d == ERR);
      locked_d   = (state_d == TRACK);
      exp_next_d = locked_d ? WIDTH'(t0_d + t1_d) : '0;
   end

   // State and registered outputs; reset wins over restart and samples
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= SEED0;
         t0_q       <= '0;
         t1_q       <= '0;
         cnt_q      <= '0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         err_q      <= 1'b0;
         locked_q   <= 1'b0;
         exp_next_q <= '0;
      end else begin
         state_q    <= state_d;
         t0_q       <= t0_d;
         t1_q       <= t1_d;
         cnt_q      <= cnt_d;
         match_q    <= match_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
         locked_q   <= locked_d;
         exp_next_q <= exp_next_d;
      end
   end

   assign bus.match      = match_q;
   assign bus.mismatch   = mismatch_q;
   assign bus.err_sticky = err_q;
   assign bus.locked     = locked_q;
   assign bus.exp_next   = exp_next_q;
   assign bus.term_count = cnt_q;
endmodule

// File: doc/fibo_checker_sync_rst.md
FIBO_CHECKER_SYNC_RST -- requirements
Module: fibo_checker_sync_rst

Interface
- REQ-001: Parameter WIDTH, default 4: bit width of sample and expected-term datapath.
- REQ-002: Parameter STRICT_SEED, default 1: 1 = first two terms must be 0 then 1; 0 = first two accepted samples are taken as the seed without checking.
- REQ-003: clk  input  1  single clock; all state updates on posedge clk.
- REQ-004: reset_n  input  1  reset, synchronous and active-low, sampled on posedge clk.
- REQ-005: in_valid  input  1  in_data carries a term this cycle.
- REQ-006: in_data  input  WIDTH  received Fibonacci term, unsigned.
- REQ-007: restart  input  1  resynchronise checker to seed state without full reset.
- REQ-008: match  output  1  registered one-cycle pulse: previous accepted sample was correct.
- REQ-009: mismatch  output  1  registered one-cycle pulse: previous accepted sample was wrong.
- REQ-010: err_sticky  output  1  high while in ERR state.
- REQ-011: exp_next  output  WIDTH  term expected at the next in_valid (valid in TRACK state only, else 0).
- REQ-012: term_count  output  8  number of matched terms since reset/restart, saturating at 255.
- REQ-013: locked  output  1  high in TRACK state.

Function
- REQ-014: FSM states SEED0, SEED1, TRACK, ERR; one sample accepted per cycle with in_valid=1, no backpressure.
- REQ-015: SEED0 + in_valid: STRICT_SEED=1 and in_data==0, or STRICT_SEED=0 -> store in_data as t0, pulse match, go SEED1; STRICT_SEED=1 and in_data!=0 -> pulse mismatch, go ERR.
- REQ-016: SEED1 + in_valid: STRICT_SEED=1 and in_data==1, or STRICT_SEED=0 -> store as t1, pulse match, go TRACK; otherwise pulse mismatch, go ERR.
- REQ-017: TRACK: exp_next = (t0 + t1) mod 2^WIDTH, carry discarded; on in_valid with in_data==exp_next -> t0<=t1, t1<=in_data, pulse match; else pulse mismatch, go ERR, t0/t1 held.
- REQ-018: ERR: in_valid ignored, no match/mismatch pulses, err_sticky=1; exit only via restart or reset.
- REQ-019: match and mismatch never high in the same cycle; each asserted exactly the cycle after the accepting edge (latency 1).
- REQ-020: term_count increments on every match pulse event (including seed terms), saturates at 255, not cleared by mismatch.
- REQ-021: in_valid=0 in any state: no state change, no pulses.
- REQ-022: restart=1 (any state): next state SEED0, t0/t1/term_count cleared, err_sticky cleared; a simultaneous in_valid sample is dropped, no pulse.
- REQ-023: Wrap-around is legal: e.g. WIDTH=4, 8 then 13 expects 5 (21 mod 16); 13 then 5 expects 2.

Reset
- REQ-024: reset_n=0 at posedge: state SEED0, t0=t1=0, match=0, mismatch=0, err_sticky=0, exp_next=0, term_count=0, locked=0.
- REQ-025: reset_n has priority over restart and in_valid; reset mid-sequence discards all history; in-flight pulse suppressed the cycle after reset.

Verification
- REQ-026: After reset, feed 0,1,1,2,3,5,8,13,5,2,7,9 on consecutive cycles (WIDTH=4) -> 12 match pulses, no mismatch, term_count=12, locked=1 from cycle after second term.
- REQ-027: Feed 0,1,1,2,4 -> match x4, mismatch on 4th edge+1, err_sticky=1, locked=0; further 7,12 produce no pulses, term_count stays 4.
- REQ-028: STRICT_SEED=1, first term 3 -> mismatch, ERR; STRICT_SEED=0, feed 3,4,7,11,2 -> 5 matches, exp_next=13 after last.
- REQ-029: In ERR assert restart with in_valid=1 in_data=0 -> no pulse, state SEED0, err_sticky=0, term_count=0; then 0,1 -> 2 matches, locked=1.
- REQ-030: Mid-TRACK (after 0,1,1,2) deassert in_valid 3 cycles -> no pulses, exp_next=3 held; then reset_n=0 one cycle -> all outputs at reset values, next sample 1 in SEED0 gives mismatch (STRICT_SEED=1).
- REQ-031: Feed 300 valid terms of a correct wrapped sequence -> term_count saturates at 255, match continues pulsing, no mismatch.
